// File: rtl/dense_pkg.sv
// Shared constants for the nine-lane dense multiply-accumulate block.
package dense_pkg;

    localparam int DEFAULT_SIZE_1 = 11;
    localparam int PIPE_LATENCY   = 2;
    localparam int NUM_LANES      = 9;

    function automatic int prodWidth(input int size);
        return 2 * size;
    endfunction

    // Nine products need 4 guard bits on top of the product width.
    function automatic int accWidth(input int size);
        return 2 * size + 4;
    endfunction

    function automatic int resultWidth(input int size);
        return 2 * size - 1;
    endfunction

    function automatic longint satMax(input int size);
        return (longint'(1) <<< (2 * size - 2)) - 1;
    endfunction

    function automatic longint satMin(input int size);
        return -(longint'(1) <<< (2 * size - 2));
    endfunction

    localparam int     DEFAULT_ACC_W   = accWidth(DEFAULT_SIZE_1);
    localparam longint DEFAULT_SAT_MAX = satMax(DEFAULT_SIZE_1);
    localparam longint DEFAULT_SAT_MIN = satMin(DEFAULT_SIZE_1);

endpackage

// File: rtl/dense_sat.sv
// Signed clip of an IN_W-bit value into OUT_W bits, flagging when the clip engages.
module dense_sat
    import dense_pkg::*;
#(
    parameter int IN_W  = DEFAULT_ACC_W,
    parameter int OUT_W = 2 * DEFAULT_SIZE_1 - 1
) (
    input  logic signed [IN_W-1:0]  i_value,
    output logic signed [OUT_W-1:0] o_value,
    output logic                    o_clip
);

    logic [IN_W-OUT_W:0] w_hiBits;
    logic                w_allZero;
    logic                w_allOne;

    // The value fits only when every bit above the result sign bit repeats it.
    assign w_hiBits  = i_value[IN_W-1:OUT_W-1];
    assign w_allZero = ~|w_hiBits;
    assign w_allOne  = &w_hiBits;

    always_comb begin
        o_value = i_value[OUT_W-1:0];
        o_clip  = 1'b0;
        if (!w_allZero && !w_allOne) begin
            o_clip = 1'b1;
            if (i_value[IN_W-1]) begin
                o_value = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_value = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/dense_mac.sv
// Two-stage nine-lane signed dot product: multiplies in stage 1, sum and clip in stage 2.
module dense_mac
    import dense_pkg::*;
#(
    parameter int SIZE_1     = DEFAULT_SIZE_1,
    parameter int NOZERO_SAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dense_en,
    input  logic                       go,
    input  logic signed [SIZE_1-1:0]   p11,
    input  logic signed [SIZE_1-1:0]   p12,
    input  logic signed [SIZE_1-1:0]   p13,
    input  logic signed [SIZE_1-1:0]   p14,
    input  logic signed [SIZE_1-1:0]   p15,
    input  logic signed [SIZE_1-1:0]   p16,
    input  logic signed [SIZE_1-1:0]   p17,
    input  logic signed [SIZE_1-1:0]   p18,
    input  logic signed [SIZE_1-1:0]   p19,
    input  logic signed [SIZE_1-1:0]   w11,
    input  logic signed [SIZE_1-1:0]   w12,
    input  logic signed [SIZE_1-1:0]   w13,
    input  logic signed [SIZE_1-1:0]   w14,
    input  logic signed [SIZE_1-1:0]   w15,
    input  logic signed [SIZE_1-1:0]   w16,
    input  logic signed [SIZE_1-1:0]   w17,
    input  logic signed [SIZE_1-1:0]   w18,
    input  logic signed [SIZE_1-1:0]   w19,
    output logic signed [2*SIZE_1-2:0] Y1,
    output logic                       valid,
    output logic                       ovf
);

    localparam int PROD_W = prodWidth(SIZE_1);
    localparam int ACC_W  = accWidth(SIZE_1);
    localparam int RES_W  = resultWidth(SIZE_1);

    logic signed [SIZE_1-1:0] w_pix [NUM_LANES];
    logic signed [SIZE_1-1:0] w_wgt [NUM_LANES];
    logic [PROD_W-1:0]        w_prod [NUM_LANES];
    logic [PROD_W-1:0]        r_prod [NUM_LANES];
    logic                     r_s1Valid;
    logic [ACC_W-1:0]         w_sum;
    logic signed [RES_W-1:0]  w_satY;
    logic                     w_clip;
    logic signed [RES_W-1:0]  r_y1;
    logic                     r_valid;
    logic                     r_ovf;

    assign w_pix[0] = p11;
    assign w_pix[1] = p12;
    assign w_pix[2] = p13;
    assign w_pix[3] = p14;
    assign w_pix[4] = p15;
    assign w_pix[5] = p16;
    assign w_pix[6] = p17;
    assign w_pix[7] = p18;
    assign w_pix[8] = p19;
    assign w_wgt[0] = w11;
    assign w_wgt[1] = w12;
    assign w_wgt[2] = w13;
    assign w_wgt[3] = w14;
    assign w_wgt[4] = w15;
    assign w_wgt[5] = w16;
    assign w_wgt[6] = w17;
    assign w_wgt[7] = w18;
    assign w_wgt[8] = w19;

    // Sign-extend both operands to the product width so the low bits form the signed product.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        assign w_prod[k] = {{SIZE_1{w_pix[k][SIZE_1-1]}}, w_pix[k]}
                         * {{SIZE_1{w_wgt[k][SIZE_1-1]}}, w_wgt[k]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                r_prod[k] <= '0;
            end
            r_s1Valid <= 1'b0;
        end else if (!dense_en) begin
            r_s1Valid <= 1'b0;
        end else begin
            r_s1Valid <= go;
            if (go) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    r_prod[k] <= w_prod[k];
                end
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_sum = w_sum + {{(ACC_W-PROD_W){r_prod[k][PROD_W-1]}}, r_prod[k]};
        end
    end

    dense_sat #(
        .IN_W  (ACC_W),
        .OUT_W (RES_W)
    ) u_sat (
        .i_value (w_sum),
        .o_value (w_satY),
        .o_clip  (w_clip)
    );

    // Dropping the enable flushes stage 2 and the sticky overflow along with stage 1.
    always_ff @(posedge clk) begin
        if (rst || !dense_en) begin
            r_y1    <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= r_s1Valid;
            if (r_s1Valid) begin
                if (NOZERO_SAT != 0) begin
                    r_y1  <= w_satY;
                    r_ovf <= r_ovf | w_clip;
                end else begin
                    r_y1 <= w_sum[RES_W-1:0];
                end
            end
        end
    end

    assign Y1    = r_y1;
    assign valid = r_valid;
    assign ovf   = r_ovf;

endmodule
